gen_burst_ctrl: RTL
===================

Name: gen_burst_ctrl

Overview:
Sequencer for funct_generator. Latches a waveform configuration, drives a timed config phase, then enables generation for a programmed number of samples. Throttles the generator while the downstream FIFO is full and reports completion. Sits between the top-level register/control logic and funct_generator; its outputs drive the generator's en_low_i, enh_conf_i, amp_i and sel_i.

Parameters:
CNT_WIDTH, 16, width of burst length and sample counter
CONF_CYCLES, 2, cycles enh_conf_o is held high in CONFIG (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start_i  input  1  start request; accepted only in IDLE
abort_i  input  1  terminate current burst
burst_len_i  input  CNT_WIDTH  samples per burst; 0 = continuous until abort
amp_cfg_i  input  INT_BITS signed  amplitude for generator
sel_cfg_i  input  2  waveform select (cos/sin/triangle/square)
fifo_full_i  input  1  downstream FIFO full
gen_wr_en_i  input  1  generator's wr_en_o; one sample produced
en_low_o  output  1  generator enable, active-low (1 = halted)
enh_conf_o  output  1  generator config-load strobe
amp_o  output  INT_BITS signed  latched amplitude
sel_o  output  2  latched select
busy_o  output  1  high outside IDLE/DONE
done_o  output  1  one-cycle completion pulse
sample_cnt_o  output  CNT_WIDTH  samples accepted this burst

Behaviour:
- Reset (rst=0, async): state IDLE; en_low_o=1, enh_conf_o=0, amp_o=0, sel_o=0, busy_o=0, done_o=0, sample_cnt_o=0. Mid-burst reset halts the generator immediately.
- All outputs registered.
- FSM states: IDLE, CONFIG, RUN, PAUSE, DONE.
- IDLE:
  - start_i=1 and abort_i=0: latch amp_cfg_i, sel_cfg_i and burst_len_i into shadow regs; clear sample_cnt_o; go to CONFIG.
  - start_i and abort_i both high: stay in IDLE.
- CONFIG:
  - enh_conf_o=1 for exactly CONF_CYCLES cycles; en_low_o=1; busy_o=1.
  - amp_o/sel_o are valid from the first CONFIG cycle.
  - After CONF_CYCLES: go to PAUSE if fifo_full_i=1, else RUN.
- RUN:
  - en_low_o=0.
  - Each gen_wr_en_i=1 increments sample_cnt_o.
  - Terminal: burst_len!=0, gen_wr_en_i=1 and sample_cnt_o==burst_len-1 -> go to DONE; en_low_o=1 next cycle.
  - Otherwise fifo_full_i=1 -> PAUSE; en_low_o=1 next cycle (one-cycle throttle latency).
  - A terminal sample that arrives in the same cycle as full is still counted.
- PAUSE: en_low_o=1; go to RUN the cycle after fifo_full_i deasserts. gen_wr_en_i in PAUSE (in-flight sample) is counted.
- DONE: done_o=1 for one cycle; busy_o=0; en_low_o=1; return to IDLE. sample_cnt_o holds until the next accepted start.
- Priority: abort_i in CONFIG/RUN/PAUSE -> DONE next cycle, over terminal count and full. start_i outside IDLE is ignored.
- Shadow configuration is frozen for the whole burst; input changes take effect only at the next start.
- Continuous mode (burst_len=0): sample_cnt_o wraps 2^CNT_WIDTH-1 -> 0; the burst ends only via abort_i.
- gen_wr_en_i in IDLE/CONFIG/DONE is ignored.

Optional Feature:
GEN_CTRL_DROP_CNT_EN
- Defined: adds output drop_cnt_o (CNT_WIDTH). It counts gen_wr_en_i=1 cycles with fifo_full_i=1 in RUN/PAUSE; saturates at all-ones; cleared on accepted start; reset 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- fifo_defines_pkg gains gen_ctrl_state_t (IDLE, CONFIG, RUN, PAUSE, DONE) and GEN_CTRL_CNT_WIDTH / GEN_CTRL_CONF_CYCLES defaults. It already provides INT_BITS.
- One sub-module: gen_ctrl_sample_cnt, a loadable/clearable counter with terminal-count compare (burst_len-1) and wrap. It is reused for the optional drop counter with a saturate option.

Test Plan:
- Reset, then start_i with burst_len=4, amp=5, sel=2, FIFO never full, gen_wr_en_i every RUN cycle -> enh_conf_o high 2 cycles; en_low_o low 4 cycles; sample_cnt_o=4; done_o pulses once; amp_o=5, sel_o=2.
- burst_len=8, fifo_full_i high after sample 3 for 5 cycles -> en_low_o=1 one cycle after full, PAUSE held 5 cycles, resume; final sample_cnt_o=8 including any in-flight sample.
- burst_len=0, run 70000 samples with CNT_WIDTH=16, then abort_i -> sample_cnt_o wraps to 4464; DONE next cycle; done_o pulse.
- abort_i during CONFIG cycle 1 -> enh_conf_o drops; done_o next cycle; en_low_o never goes low.
- start_i and abort_i together in IDLE; later start_i during RUN -> no state change / ignored; shadow amp/sel unchanged.
- rst asserted mid-RUN -> en_low_o=1 and all outputs at reset values asynchronously. With GEN_CTRL_DROP_CNT_EN: 3 samples during full -> drop_cnt_o=3.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
// ============================================================================
// Module : fifo_defines_pkg
// Brief  : Shared widths and types for the FIFO / function-generator path.
// Rev    : 1.1 - adds gen_burst_ctrl state type and defaults
// ============================================================================
`default_nettype none

package fifo_defines_pkg;

    localparam int INT_BITS = 16;

    localparam int GEN_CTRL_CNT_WIDTH   = 16;
    localparam int GEN_CTRL_CONF_CYCLES = 2;

    typedef enum logic [2:0] {
        GC_IDLE   = 3'd0,
        GC_CONFIG = 3'd1,
        GC_RUN    = 3'd2,
        GC_PAUSE  = 3'd3,
        GC_DONE   = 3'd4
    } gen_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/gen_ctrl_sample_cnt.sv
// ============================================================================
// Module : gen_ctrl_sample_cnt
// Brief  : Clearable up-counter with terminal compare (len-1); wraps or saturates.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_ctrl_sample_cnt
    import fifo_defines_pkg::*;
#(
    parameter int CNT_WIDTH = GEN_CTRL_CNT_WIDTH,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 term_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;

    generate
        if (SATURATE) begin : g_sat
            assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end else begin : g_wrap
            assign cnt_inc = cnt_q + CNT_WIDTH'(1);
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    // A zero length means "no terminal count" (continuous mode).
    assign term_o = (len_i != '0) && (cnt_q == len_i - CNT_WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/gen_burst_ctrl.sv
// ============================================================================
// Module : gen_burst_ctrl
// Brief  : Burst sequencer for funct_generator: config phase, counted run,
//          FIFO-full throttling and completion pulse.
//          Optional macro GEN_CTRL_DROP_CNT_EN adds drop_cnt_o.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_burst_ctrl
    import fifo_defines_pkg::*;
#(
    parameter int CNT_WIDTH   = GEN_CTRL_CNT_WIDTH,
    parameter int CONF_CYCLES = GEN_CTRL_CONF_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [CNT_WIDTH-1:0]       burst_len_i,
    input  logic signed [INT_BITS-1:0] amp_cfg_i,
    input  logic [1:0]                 sel_cfg_i,
    input  logic                       fifo_full_i,
    input  logic                       gen_wr_en_i,
    output logic                       en_low_o,
    output logic                       enh_conf_o,
    output logic signed [INT_BITS-1:0] amp_o,
    output logic [1:0]                 sel_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CNT_WIDTH-1:0]       sample_cnt_o
`ifdef GEN_CTRL_DROP_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]       drop_cnt_o
`endif
);

    localparam int                CONF_W    = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_CYCLES - 1);

    gen_ctrl_state_t            state_q, state_d;
    logic [CONF_W-1:0]          conf_cnt_q, conf_cnt_d;
    logic signed [INT_BITS-1:0] amp_q, amp_d;
    logic [1:0]                 sel_q, sel_d;
    logic [CNT_WIDTH-1:0]       len_q, len_d;
    logic                       en_low_q, en_low_d;
    logic                       enh_conf_q, enh_conf_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic accept;
    logic active;
    logic sample_inc;
    logic cnt_term;
    logic term_hit;

    assign accept     = (state_q == GC_IDLE) && start_i && !abort_i;
    assign active     = (state_q == GC_RUN) || (state_q == GC_PAUSE);
    assign sample_inc = active && gen_wr_en_i;
    // An in-flight sample landing in PAUSE can also complete the burst.
    assign term_hit   = sample_inc && cnt_term;

    gen_ctrl_sample_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .SATURATE  (1'b0)
    ) u_sample_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .inc_i  (sample_inc),
        .len_i  (len_q),
        .cnt_o  (sample_cnt_o),
        .term_o (cnt_term)
    );

`ifdef GEN_CTRL_DROP_CNT_EN
    logic drop_term_unused;

    gen_ctrl_sample_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .SATURATE  (1'b1)
    ) u_drop_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .inc_i  (sample_inc && fifo_full_i),
        .len_i  ('0),
        .cnt_o  (drop_cnt_o),
        .term_o (drop_term_unused)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= GC_IDLE;
            conf_cnt_q <= '0;
            amp_q      <= '0;
            sel_q      <= '0;
            len_q      <= '0;
            en_low_q   <= 1'b1;
            enh_conf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            conf_cnt_q <= conf_cnt_d;
            amp_q      <= amp_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            en_low_q   <= en_low_d;
            enh_conf_q <= enh_conf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conf_cnt_d = conf_cnt_q;
        amp_d      = amp_q;
        sel_d      = sel_q;
        len_d      = len_q;
        case (state_q)
            GC_IDLE: begin
                if (accept) begin
                    state_d    = GC_CONFIG;
                    conf_cnt_d = '0;
                    amp_d      = amp_cfg_i;
                    sel_d      = sel_cfg_i;
                    len_d      = burst_len_i;
                end
            end
            GC_CONFIG: begin
                conf_cnt_d = conf_cnt_q + CONF_W'(1);
                if (abort_i) begin
                    state_d = GC_DONE;
                end else if (conf_cnt_q == CONF_LAST) begin
                    state_d = fifo_full_i ? GC_PAUSE : GC_RUN;
                end
            end
            GC_RUN: begin
                if (abort_i || term_hit) begin
                    state_d = GC_DONE;
                end else if (fifo_full_i) begin
                    state_d = GC_PAUSE;
                end
            end
            GC_PAUSE: begin
                if (abort_i || term_hit) begin
                    state_d = GC_DONE;
                end else if (!fifo_full_i) begin
                    state_d = GC_RUN;
                end
            end
            GC_DONE: begin
                state_d = GC_IDLE;
            end
            default: begin
                state_d = GC_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        en_low_d   = (state_d != GC_RUN);
        enh_conf_d = (state_d == GC_CONFIG);
        busy_d     = (state_d == GC_CONFIG) || (state_d == GC_RUN) || (state_d == GC_PAUSE);
        done_d     = (state_d == GC_DONE);
    end

    assign en_low_o   = en_low_q;
    assign enh_conf_o = enh_conf_q;
    assign amp_o      = amp_q;
    assign sel_o      = sel_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire
